// File: rtl/traffic_safety_monitor.sv
// Safety monitor between the traffic light controller and the lamp drivers.
// Filters illegal/conflicting requests, checks sequencing and hold time, and forces flashing red on fault.
module traffic_safety_monitor #(
  parameter int unsigned MAX_HOLD_TICKS = 8,
  parameter int unsigned FILTER_CYCLES  = 2,
  parameter int unsigned RECOVER_TICKS  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       ns_g,
  input  logic       ns_y,
  input  logic       ns_r,
  input  logic       ew_g,
  input  logic       ew_y,
  input  logic       ew_r,
  input  logic       clear_fault,
  output logic       lamp_ns_g,
  output logic       lamp_ns_y,
  output logic       lamp_ns_r,
  output logic       lamp_ew_g,
  output logic       lamp_ew_y,
  output logic       lamp_ew_r,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned WW = $clog2(MAX_HOLD_TICKS + 1);
  localparam int unsigned RW = $clog2(RECOVER_TICKS + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [FW-1:0] FILT_MAX  = FW'(FILTER_CYCLES);
  localparam logic [WW-1:0] WD_LAST   = WW'(MAX_HOLD_TICKS - 1);
  localparam logic [RW-1:0] REC_LAST  = RW'(RECOVER_TICKS - 1);
  localparam logic [5:0]    ALL_RED   = 6'b001_001;

  typedef enum logic [1:0] {RECOVER, PASS, FLASH} state_t;

  state_t        state;
  logic [5:0]    s, s_prev, lamps;
  logic [FW-1:0] filt_cnt;
  logic [WW-1:0] wd_cnt;
  logic [RW-1:0] rec_cnt;
  logic          phase;

  logic       illegal, conflict, bad, prev_clean, changed;
  logic       filt_hit, seq_err, stuck, latch, phase_next;
  logic [2:0] latch_code;

  function automatic logic one_hot3(input logic [2:0] v);
    return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
  endfunction

  // Pattern bits are {g, y, r}: forbidden steps are g->r, y->g, r->y.
  function automatic logic bad_step(input logic [2:0] from, input logic [2:0] to);
    return (from == 3'b100 && to == 3'b001) ||
           (from == 3'b010 && to == 3'b100) ||
           (from == 3'b001 && to == 3'b010);
  endfunction

  function automatic logic clean6(input logic [5:0] v);
    return one_hot3(v[5:3]) && one_hot3(v[2:0]) && (v[3] || v[0]);
  endfunction

  always_comb begin
    illegal    = !(one_hot3(s[5:3]) && one_hot3(s[2:0]));
    conflict   = !illegal && !s[3] && !s[0];
    bad        = illegal || conflict;
    prev_clean = clean6(s_prev);
    changed    = (s != s_prev);
    filt_hit   = bad && (filt_cnt >= FILT_LAST);
    // Steps into or out of a conflicting pattern are left to the glitch filter.
    seq_err    = (state == PASS) && changed && !bad && prev_clean &&
                 (bad_step(s_prev[5:3], s[5:3]) || bad_step(s_prev[2:0], s[2:0]));
    stuck      = (state == PASS) && !changed && tick && (wd_cnt == WD_LAST);
    latch      = (state != FLASH) && (filt_hit || seq_err || stuck);
    latch_code = filt_hit ? (illegal ? 3'd1 : 3'd2) : (seq_err ? 3'd3 : 3'd4);
    phase_next = tick ? ~phase : phase;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RECOVER;
      s          <= '0;
      s_prev     <= '0;
      lamps      <= ALL_RED;
      fault      <= 1'b0;
      fault_code <= '0;
      filt_cnt   <= '0;
      wd_cnt     <= '0;
      rec_cnt    <= '0;
      phase      <= 1'b1;
    end else begin
      s      <= {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};
      s_prev <= s;
      if (!bad)                     filt_cnt <= '0;
      else if (filt_cnt != FILT_MAX) filt_cnt <= filt_cnt + 1'b1;

      if (latch) begin
        state      <= FLASH;
        fault      <= 1'b1;
        fault_code <= latch_code;
        phase      <= 1'b1;
        lamps      <= ALL_RED;
      end else begin
        case (state)
          RECOVER: begin
            lamps  <= ALL_RED;
            wd_cnt <= '0;
            if (tick) begin
              if (rec_cnt == REC_LAST) begin
                rec_cnt <= '0;
                if (!bad) state <= PASS;
              end else begin
                rec_cnt <= rec_cnt + 1'b1;
              end
            end
          end
          PASS: begin
            lamps <= bad ? ALL_RED : s;
            if (changed)   wd_cnt <= '0;
            else if (tick) wd_cnt <= wd_cnt + 1'b1;
          end
          FLASH: begin
            if (clear_fault && !bad) begin
              state      <= RECOVER;
              fault      <= 1'b0;
              fault_code <= '0;
              rec_cnt    <= '0;
              lamps      <= ALL_RED;
            end else begin
              phase <= phase_next;
              lamps <= {2'b00, phase_next, 2'b00, phase_next};
            end
          end
          default: state <= RECOVER;
        endcase
      end
    end
  end

  assign {lamp_ns_g, lamp_ns_y, lamp_ns_r, lamp_ew_g, lamp_ew_y, lamp_ew_r} = lamps;

endmodule

// File: tb/tb_traffic_safety_monitor.sv
// Randomized and directed bench for traffic_safety_monitor against a colour-index reference model.
module tb_traffic_safety_monitor;

  localparam int MAX_HOLD = 8;
  localparam int FILTER   = 2;
  localparam int RECOVER  = 3;
  localparam logic [5:0] RED     = 6'b001_001;
  localparam logic [5:0] NSG_EWR = 6'b100_001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic ns_g = 1'b0, ns_y = 1'b0, ns_r = 1'b0, ew_g = 1'b0, ew_y = 1'b0, ew_r = 1'b0;
  logic clear_fault = 1'b0;
  logic lamp_ns_g, lamp_ns_y, lamp_ns_r, lamp_ew_g, lamp_ew_y, lamp_ew_r;
  logic fault;
  logic [2:0] fault_code;
  logic [5:0] dut_lamps;
  bit tick_rand = 1'b0;

  int checks = 0;
  int errors = 0;

  traffic_safety_monitor #(
    .MAX_HOLD_TICKS(MAX_HOLD),
    .FILTER_CYCLES (FILTER),
    .RECOVER_TICKS (RECOVER)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r),
    .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
    .clear_fault(clear_fault),
    .lamp_ns_g(lamp_ns_g), .lamp_ns_y(lamp_ns_y), .lamp_ns_r(lamp_ns_r),
    .lamp_ew_g(lamp_ew_g), .lamp_ew_y(lamp_ew_y), .lamp_ew_r(lamp_ew_r),
    .fault(fault), .fault_code(fault_code)
  );

  assign dut_lamps = {lamp_ns_g, lamp_ns_y, lamp_ns_r, lamp_ew_g, lamp_ew_y, lamp_ew_r};

  always #5 clk = ~clk;

  // Colour index of one direction: 0 green, 1 yellow, 2 red, -1 not a single lamp.
  function automatic int color(input logic [2:0] v);
    case (v)
      3'b100:  return 0;
      3'b010:  return 1;
      3'b001:  return 2;
      default: return -1;
    endcase
  endfunction

  // Legal progress is staying put or advancing one colour around g->y->r->g.
  function automatic bit step_ok(input int from, input int to);
    return ((to - from + 3) % 3) <= 1;
  endfunction

  localparam int M_REC = 0, M_PASS = 1, M_FLASH = 2;
  int m_mode = M_REC;
  int bad_run = 0, rec_ticks = 0, still_ticks = 0, flash_ticks = 0;
  logic [5:0] m_s = '0, m_prev = '0, m_lamps = RED;
  logic m_fault = 1'b0;
  logic [2:0] m_code = '0;

  initial begin : ref_model
    int cn, ce, pn, pe, code;
    bit ill, con, bad;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = M_REC; bad_run = 0; rec_ticks = 0; still_ticks = 0; flash_ticks = 0;
        m_s = '0; m_prev = '0; m_lamps = RED; m_fault = 1'b0; m_code = '0;
      end else begin
        cn = color(m_s[5:3]);    ce = color(m_s[2:0]);
        pn = color(m_prev[5:3]); pe = color(m_prev[2:0]);
        ill = (cn < 0) || (ce < 0);
        con = !ill && (cn != 2) && (ce != 2);
        bad = ill || con;
        bad_run = bad ? bad_run + 1 : 0;
        code = 0;
        if (m_mode != M_FLASH) begin
          if (bad_run >= FILTER)
            code = ill ? 1 : 2;
          else if (m_mode == M_PASS && m_s != m_prev && !bad && pn >= 0 && pe >= 0 &&
                   (pn == 2 || pe == 2) && !(step_ok(pn, cn) && step_ok(pe, ce)))
            code = 3;
          else if (m_mode == M_PASS && m_s == m_prev && tick && still_ticks + 1 >= MAX_HOLD)
            code = 4;
        end
        if (code != 0) begin
          m_mode = M_FLASH; m_fault = 1'b1; m_code = 3'(code); flash_ticks = 0; m_lamps = RED;
        end else if (m_mode == M_REC) begin
          m_lamps = RED;
          still_ticks = 0;
          if (tick) begin
            rec_ticks++;
            if (rec_ticks == RECOVER) begin
              rec_ticks = 0;
              if (!bad) m_mode = M_PASS;
            end
          end
        end else if (m_mode == M_PASS) begin
          m_lamps = bad ? RED : m_s;
          if (m_s != m_prev) still_ticks = 0;
          else if (tick)     still_ticks++;
        end else begin
          if (clear_fault && !bad) begin
            m_mode = M_REC; m_fault = 1'b0; m_code = '0; rec_ticks = 0; m_lamps = RED;
          end else begin
            if (tick) flash_ticks++;
            m_lamps = (flash_ticks % 2 == 0) ? RED : 6'b000_000;
          end
        end
        m_prev = m_s;
        m_s = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      checks++;
      if (dut_lamps !== m_lamps) begin
        errors++;
        $display("FAIL lamps t=%0t got %b expected %b", $time, dut_lamps, m_lamps);
      end
      checks++;
      if (fault !== m_fault) begin
        errors++;
        $display("FAIL fault t=%0t got %b expected %b", $time, fault, m_fault);
      end
      checks++;
      if (fault_code !== m_code) begin
        errors++;
        $display("FAIL fault_code t=%0t got %0d expected %0d", $time, fault_code, m_code);
      end
    end
  end

  initial begin : tick_gen
    int div = 0;
    forever begin
      @(negedge clk);
      if (tick_rand) begin
        tick = ($urandom_range(0, 5) == 0);
      end else begin
        tick = (div == 9);
        div = (div == 9) ? 0 : div + 1;
      end
    end
  end

  task automatic drive(input logic [5:0] p);
    {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = p;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear_fault = 1'b1;
    cycles(1);
    clear_fault = 1'b0;
  endtask

  task automatic expect_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_lamps(input logic [5:0] want, input int limit, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      if (dut_lamps === want) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: lamps %b never reached %b within %0d clks", name, dut_lamps, want, limit);
    end
  endtask

  task automatic wait_fault(input int limit, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      if (fault === 1'b1) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: fault %b not raised within %0d clks", name, fault, limit);
    end
  endtask

  initial begin : main
    logic [5:0] legal [5];
    legal[0] = 6'b100_001; legal[1] = 6'b010_001; legal[2] = 6'b001_001;
    legal[3] = 6'b001_100; legal[4] = 6'b001_010;

    drive(NSG_EWR);
    cycles(3);
    expect_eq("reset_lamps", int'(dut_lamps), int'(RED));
    expect_eq("reset_fault", int'(fault), 0);
    expect_eq("reset_code", int'(fault_code), 0);
    rst_n = 1'b1;

    wait_lamps(NSG_EWR, 100, "recover_to_pass");
    expect_eq("pass_no_fault", int'(fault), 0);

    drive(6'b100_100);
    cycles(1);
    drive(NSG_EWR);
    cycles(1);
    expect_eq("glitch_all_red", int'(dut_lamps), int'(RED));
    cycles(3);
    expect_eq("glitch_no_fault", int'(fault), 0);

    drive(6'b100_100);
    cycles(3);
    drive(NSG_EWR);
    cycles(2);
    expect_eq("conflict_fault", int'(fault), 1);
    expect_eq("conflict_code", int'(fault_code), 2);
    wait_lamps(6'b000_000, 30, "flash_dark_phase");
    wait_lamps(RED, 30, "flash_red_phase");

    drive(6'b110_001);
    cycles(2);
    pulse_clear();
    cycles(2);
    expect_eq("clear_ignored", int'(fault), 1);
    drive(NSG_EWR);
    cycles(2);
    pulse_clear();
    cycles(2);
    expect_eq("clear_fault", int'(fault), 0);
    expect_eq("clear_code", int'(fault_code), 0);
    wait_lamps(NSG_EWR, 100, "clear_to_pass");

    drive(6'b001_001);
    cycles(3);
    expect_eq("seq_code", int'(fault_code), 3);
    drive(NSG_EWR);
    cycles(2);
    pulse_clear();
    wait_lamps(NSG_EWR, 100, "seq_recover");

    wait_fault(200, "stuck_raise");
    expect_eq("stuck_code", int'(fault_code), 4);
    pulse_clear();
    wait_lamps(NSG_EWR, 100, "stuck_recover");

    cycles(45);
    drive(6'b010_001); cycles(5);
    drive(6'b001_001); cycles(5);
    drive(6'b001_100); cycles(5);
    drive(6'b001_010); cycles(5);
    drive(6'b001_001); cycles(5);
    drive(NSG_EWR);    cycles(5);
    expect_eq("legal_cycle_no_fault", int'(fault), 0);

    drive(6'b100_100);
    cycles(3);
    drive(NSG_EWR);
    cycles(1);
    expect_eq("pre_reset_fault", int'(fault), 1);
    #2 rst_n = 1'b0;
    #1;
    expect_eq("async_reset_lamps", int'(dut_lamps), int'(RED));
    expect_eq("async_reset_fault", int'(fault), 0);
    expect_eq("async_reset_code", int'(fault_code), 0);
    @(negedge clk);
    cycles(2);
    rst_n = 1'b1;

    tick_rand = 1'b1;
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 9) < 7) drive(legal[$urandom_range(0, 4)]);
      else                          drive(6'($urandom));
      for (int c = 0; c < int'($urandom_range(1, 40)); c++) begin
        clear_fault = ($urandom_range(0, 9) == 0);
        cycles(1);
      end
    end
    clear_fault = 1'b0;
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
